regfile_wr_arbiter: RTL and testbench
=====================================

// Module: regfile_wr_arbiter
// PURPOSE
//  Shares the N_WAY physical-register-file write ports among N_REQ completing functional units.
//  - Each cycle, picks up to N_PORT valid completions by rotating priority.
//  - Registers the winners onto the regfile write bus (wr_en/wr_idx/wr_data).
//  - Mirrors the same winners onto the CDB broadcast.
//  - Sits between the FU result stages and regfile; losers stall via ready.
// PARAMETERS
//  N_REQ   4          number of requesting functional units
//  N_PORT  `N_WAY     regfile write ports / CDB lanes
//  TAG_W   `CDB_BITS  physical register tag width
//  DATA_W  `XLEN      result data width
// PORTS
//  clock      in   1               single clock, all state on posedge
//  reset      in   1               asynchronous, active-low; clears all state
//  flush      in   1               squash: no grants this cycle, outputs cleared next cycle
//  req_valid  in   N_REQ           FU i has a result
//  req_tag    in   N_REQ*TAG_W     destination physical register of FU i
//  req_data   in   N_REQ*DATA_W    result value of FU i
//  req_ready  out  N_REQ           combinational grant; FU i result consumed this cycle
//  wr_en      out  N_PORT          regfile write enable per port (registered)
//  wr_idx     out  N_PORT*TAG_W    regfile write index per port (registered)
//  wr_data    out  N_PORT*DATA_W   regfile write data per port (registered)
//  cdb_valid  out  N_PORT          CDB lane valid (registered)
//  cdb_tag    out  N_PORT*TAG_W    CDB lane tag (registered, equals wr_idx)
// BEHAVIOUR
//  Reset state:
//  - While reset is 0: all outputs 0 and rr_ptr = 0.
//  - req_ready is 0 whenever reset is asserted.
//  Grant selection (combinational):
//  - Scan requesters rr_ptr, rr_ptr+1, ... mod N_REQ.
//  - The first min(N_PORT, popcount(req_valid)) valid requesters win.
//  - k-th winner in scan order is assigned port k; unused ports idle.
//  - req_ready[i] = 1 iff i won. Handshake = valid & ready.
//  - A requester holding valid without ready must keep tag/data stable.
//  Latency:
//  - Exactly one cycle: winners at posedge t appear on wr_*/cdb_* during cycle t+1.
//  - Idle ports register wr_en = 0 and cdb_valid = 0.
//  - Idle-port wr_idx and wr_data hold their previous values.
//  Pointer update:
//  - If >= 1 grant, rr_ptr <= (index of last winner + 1) mod N_REQ.
//  - Else rr_ptr is unchanged.
//  - Fairness bound: a continuously valid requester wins within ceil(N_REQ/N_PORT) cycles.
//  Zero register:
//  - A winner with tag == `ZERO_REG_PR still takes a port and cdb_valid = 1 (ROB completion).
//  - Its wr_en is forced 0.
//  Flush:
//  - flush = 1 gives req_ready = 0 and rr_ptr unchanged.
//  - Next cycle all wr_en and cdb_valid are 0.
//  - flush overrides grants in the same cycle.
//  Simultaneous events / boundaries:
//  - All N_REQ valid: exactly N_PORT grants.
//  - No valid requesters: zero grants; rr_ptr holds.
//  - N_REQ <= N_PORT: every valid request is granted every cycle.
//  - rr_ptr wraps from N_REQ-1 to 0.
//  Reset mid-operation:
//  - Pending outputs are dropped; rr_ptr returns to 0.
//  - Ungranted FU results remain the FU's responsibility.
//  Protocol check:
//  - Two granted lanes with equal non-zero tag in one cycle is a protocol error.
//  - Flagged by an assertion under `TESTBENCH only; no RTL handling.
// STRUCTURE
//  - Shared package sys_defs_pkg: wb_req_t {valid, tag[TAG_W], data[DATA_W]} and wb_lane_t {en, tag, data}.
//  - Shared package also holds ZERO_REG_PR and the N_WAY/CDB_BITS/XLEN constants.
//  - Sub-module rr_multi_picker: pure combinational N_REQ-in, N_PORT-out rotating picker.
//    Inputs: rr_ptr, valid. Outputs: grant vector, per-port index, per-port hit.
//  - Parent holds rr_ptr, the output registers and the flush/zero-reg logic.
// TESTING (N_REQ=4, N_PORT=2)
//  1. Reset: reset=0 with all req_valid=1 -> req_ready=0; all wr_en=0, cdb_valid=0. Release -> grants FU0,FU1 -> next cycle wr_idx={tag1,tag0}, wr_en=2'b11.
//  2. Rotation: all 4 valid every cycle.
//     - Grant sequence {0,1},{2,3},{0,1}; rr_ptr 0->2->0.
//     - No FU waits more than 2 cycles.
//  3. Sparse: only FU3 valid, rr_ptr=1 -> FU3 on port 0, port 1 idle (wr_en=2'b01); rr_ptr -> 0.
//  4. Zero reg: FU0 tag=`ZERO_REG_PR data=32'hDEAD, FU2 tag=5 -> wr_en=2'b10, cdb_valid=2'b11, wr_idx[1]=5.
//  5. Flush: all valid with flush=1 -> req_ready=0, rr_ptr holds; next cycle wr_en=0. Following cycle resumes from the same rr_ptr.
//  6. Regfile integration: 32 sequential results to tags 0..31 through the arbiter into regfile.
//     - Readback gives registers[i]==i for i!=0 and registers[0]==0.

Source files
------------

// File: rtl/sys_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sys_defs_pkg
// Brief   : Shared machine widths, zero-register tag and writeback record types
// Revision: 1.0
// ============================================================================
package sys_defs_pkg;

    localparam int N_WAY    = 2;
    localparam int CDB_BITS = 5;
    localparam int XLEN     = 32;

    localparam logic [CDB_BITS-1:0] ZERO_REG_PR = '0;

    typedef struct packed {
        logic                valid;
        logic [CDB_BITS-1:0] tag;
        logic [XLEN-1:0]     data;
    } wb_req_t;

    typedef struct packed {
        logic                en;
        logic [CDB_BITS-1:0] tag;
        logic [XLEN-1:0]     data;
    } wb_lane_t;

endpackage
`default_nettype wire

// File: rtl/rr_multi_picker.sv
`default_nettype none
// ============================================================================
// Module  : rr_multi_picker
// Brief   : Combinational rotating picker, up to N_PORT winners among N_REQ
// Revision: 1.0
// ============================================================================
module rr_multi_picker #(
    parameter int N_REQ  = 4,
    parameter int N_PORT = 2,
    parameter int PTR_W  = 2
) (
    input  logic [PTR_W-1:0]        rr_ptr,
    input  logic [N_REQ-1:0]        valid,
    output logic [N_REQ-1:0]        grant,
    output logic [N_PORT*PTR_W-1:0] port_idx,
    output logic [N_PORT-1:0]       port_hit
);

    int w_idx;
    int w_cnt;

    // k-th valid requester in scan order (starting at rr_ptr) lands on port k
    always_comb begin
        grant    = '0;
        port_idx = '0;
        port_hit = '0;
        w_cnt    = 0;
        w_idx    = 0;
        for (int s = 0; s < N_REQ; s++) begin
            w_idx = int'(rr_ptr) + s;
            if (w_idx >= N_REQ) begin
                w_idx = w_idx - N_REQ;
            end
            if (valid[w_idx] && (w_cnt < N_PORT)) begin
                grant[w_idx]                     = 1'b1;
                port_idx[w_cnt*PTR_W +: PTR_W]   = PTR_W'(w_idx);
                port_hit[w_cnt]                  = 1'b1;
                w_cnt                            = w_cnt + 1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : regfile_wr_arbiter
// Brief   : Shares regfile write ports / CDB lanes among completing FUs
// Revision: 1.0
// ============================================================================
module regfile_wr_arbiter
    import sys_defs_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int N_PORT = N_WAY,
    parameter int TAG_W  = CDB_BITS,
    parameter int DATA_W = XLEN
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*TAG_W-1:0]   req_tag,
    input  logic [N_REQ*DATA_W-1:0]  req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic [N_PORT-1:0]        wr_en,
    output logic [N_PORT*TAG_W-1:0]  wr_idx,
    output logic [N_PORT*DATA_W-1:0] wr_data,
    output logic [N_PORT-1:0]        cdb_valid,
    output logic [N_PORT*TAG_W-1:0]  cdb_tag
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0]                r_rr_ptr;
    logic [N_PORT-1:0]               r_wr_en;
    logic [N_PORT-1:0]               r_cdb_valid;
    logic [N_PORT-1:0][TAG_W-1:0]    r_wr_idx;
    logic [N_PORT-1:0][DATA_W-1:0]   r_wr_data;

    logic [N_REQ-1:0]                w_valid;
    logic [N_REQ-1:0]                w_grant;
    logic [N_PORT*PTR_W-1:0]         w_port_idx;
    logic [N_PORT-1:0]               w_port_hit;
    logic [N_PORT-1:0][TAG_W-1:0]    w_sel_tag;
    logic [N_PORT-1:0][DATA_W-1:0]   w_sel_data;
    logic [PTR_W-1:0]                w_last;
    logic [PTR_W-1:0]                w_next_ptr;
    logic                            w_any;

    // Flush hides every request from the picker, so no grant and no pointer move
    assign w_valid   = flush ? '0 : req_valid;
    assign req_ready = reset ? w_grant : '0;

    rr_multi_picker #(
        .N_REQ  (N_REQ),
        .N_PORT (N_PORT),
        .PTR_W  (PTR_W)
    ) u_picker (
        .rr_ptr   (r_rr_ptr),
        .valid    (w_valid),
        .grant    (w_grant),
        .port_idx (w_port_idx),
        .port_hit (w_port_hit)
    );

    always_comb begin
        w_last = '0;
        w_any  = 1'b0;
        for (int p = 0; p < N_PORT; p++) begin
            w_sel_tag[p]  = req_tag[int'(w_port_idx[p*PTR_W +: PTR_W])*TAG_W +: TAG_W];
            w_sel_data[p] = req_data[int'(w_port_idx[p*PTR_W +: PTR_W])*DATA_W +: DATA_W];
            if (w_port_hit[p]) begin
                w_any  = 1'b1;
                w_last = w_port_idx[p*PTR_W +: PTR_W];
            end
        end
        w_next_ptr = (w_last == PTR_W'(N_REQ - 1)) ? '0 : w_last + PTR_W'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rr_ptr    <= '0;
            r_wr_en     <= '0;
            r_cdb_valid <= '0;
            r_wr_idx    <= '0;
            r_wr_data   <= '0;
        end else begin
            if (w_any) begin
                r_rr_ptr <= w_next_ptr;
            end
            for (int p = 0; p < N_PORT; p++) begin
                // Zero-register winners still complete on the CDB but never write
                r_cdb_valid[p] <= w_port_hit[p];
                r_wr_en[p]     <= w_port_hit[p] && (w_sel_tag[p] != TAG_W'(ZERO_REG_PR));
                if (w_port_hit[p]) begin
                    r_wr_idx[p]  <= w_sel_tag[p];
                    r_wr_data[p] <= w_sel_data[p];
                end
            end
        end
    end

    assign wr_en     = r_wr_en;
    assign wr_idx    = r_wr_idx;
    assign wr_data   = r_wr_data;
    assign cdb_valid = r_cdb_valid;
    assign cdb_tag   = r_wr_idx;

`ifdef TESTBENCH
    always @(posedge clock) begin
        if (reset) begin
            for (int a = 0; a < N_PORT; a++) begin
                for (int b = a + 1; b < N_PORT; b++) begin
                    a_dup_tag: assert (!(w_port_hit[a] && w_port_hit[b] &&
                                         (w_sel_tag[a] == w_sel_tag[b]) &&
                                         (w_sel_tag[a] != TAG_W'(ZERO_REG_PR))));
                end
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_regfile_wr_arbiter
// Brief   : Scoreboard bench for regfile_wr_arbiter (N_REQ=4, N_PORT=2)
// Revision: 1.0
// ============================================================================
module tb_regfile_wr_arbiter;

    logic         clock = 1'b0;
    logic         rst_n;
    logic         flush;
    logic [3:0]   req_valid;
    logic [19:0]  req_tag;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic [1:0]   wr_en;
    logic [9:0]   wr_idx;
    logic [63:0]  wr_data;
    logic [1:0]   cdb_valid;
    logic [9:0]   cdb_tag;

    int checks = 0;
    int errors = 0;

    logic [4:0]  tags  [4];
    logic [31:0] datas [4];
    logic [31:0] regs  [32];

    typedef struct {
        logic [1:0]  en;
        logic [1:0]  cdb;
        logic [4:0]  t0;
        logic [4:0]  t1;
        logic [31:0] d0;
        logic [31:0] d1;
    } exp_t;

    exp_t sb[$];
    exp_t me;

    regfile_wr_arbiter #(
        .N_REQ  (4),
        .N_PORT (2),
        .TAG_W  (5),
        .DATA_W (32)
    ) dut (
        .clock     (clock),
        .reset     (rst_n),
        .flush     (flush),
        .req_valid (req_valid),
        .req_tag   (req_tag),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic f);
        req_valid = v;
        flush     = f;
        req_tag   = {tags[3], tags[2], tags[1], tags[0]};
        req_data  = {datas[3], datas[2], datas[1], datas[0]};
    endtask

    // Drive one cycle, check the grant, queue the output expected next cycle
    task automatic step(input logic [3:0] v, input logic f, input logic [3:0] er,
                        input logic [1:0] ecdb, input logic [1:0] een,
                        input int fu0, input int fu1);
        exp_t e;
        drive(v, f);
        #3;
        chk("req_ready", req_ready, er);
        if (ecdb != 2'b00) begin
            e.en  = een;
            e.cdb = ecdb;
            e.t0  = tags[fu0];
            e.d0  = datas[fu0];
            e.t1  = tags[fu1];
            e.d1  = datas[fu1];
            sb.push_back(e);
        end
        @(posedge clock);
        #1;
    endtask

    // Monitor: compares whenever the DUT presents CDB traffic
    always @(negedge clock) begin
        if (rst_n && (cdb_valid != 2'b00)) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", {62'd0, cdb_valid}, 64'd0);
            end else begin
                me = sb.pop_front();
                chk("cdb_valid", cdb_valid, me.cdb);
                chk("wr_en", wr_en, me.en);
                chk("cdb_tag_eq_wr_idx", cdb_tag, wr_idx);
                if (me.cdb[0]) chk("lane0_tag", wr_idx[4:0], me.t0);
                if (me.cdb[1]) chk("lane1_tag", wr_idx[9:5], me.t1);
                if (me.en[0])  chk("lane0_data", wr_data[31:0], me.d0);
                if (me.en[1])  chk("lane1_data", wr_data[63:32], me.d1);
            end
        end
    end

    // Regfile fed by the arbiter's write bus
    always @(negedge clock) begin
        if (rst_n) begin
            for (int p = 0; p < 2; p++) begin
                if (wr_en[p]) regs[wr_idx[p*5 +: 5]] <= wr_data[p*32 +: 32];
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        for (int i = 0; i < 4; i++) begin
            tags[i]  = 5'(8 + i);
            datas[i] = 32'hA000_0000 + 32'(i);
        end
        rst_n = 1'b0;
        drive(4'b1111, 1'b0);
        #2;
        chk("reset_ready", req_ready, 4'b0000);
        chk("reset_wr_en", wr_en, 2'b00);
        chk("reset_cdb_valid", cdb_valid, 2'b00);
        chk("reset_wr_idx", wr_idx, 10'd0);
        @(posedge clock);
        #1;
        rst_n = 1'b1;

        // Release: FU0,FU1 then rotation
        step(4'b1111, 1'b0, 4'b0011, 2'b11, 2'b11, 0, 1);
        step(4'b1111, 1'b0, 4'b1100, 2'b11, 2'b11, 2, 3);
        step(4'b1111, 1'b0, 4'b0011, 2'b11, 2'b11, 0, 1);
        // Sparse: pointer 2 -> FU0 wins alone; pointer 1 -> FU3 wins alone
        step(4'b0001, 1'b0, 4'b0001, 2'b01, 2'b01, 0, 0);
        step(4'b1000, 1'b0, 4'b1000, 2'b01, 2'b01, 3, 0);
        // Idle cycle leaves the pointer at 0
        step(4'b0000, 1'b0, 4'b0000, 2'b00, 2'b00, 0, 0);
        step(4'b1111, 1'b0, 4'b0011, 2'b11, 2'b11, 0, 1);
        step(4'b1111, 1'b0, 4'b1100, 2'b11, 2'b11, 2, 3);

        // Zero register on port 0, tag 5 on port 1
        tags[0]  = 5'd0;
        datas[0] = 32'hDEAD;
        tags[2]  = 5'd5;
        step(4'b0101, 1'b0, 4'b0101, 2'b11, 2'b10, 0, 2);
        tags[0]  = 5'd8;
        datas[0] = 32'hA000_0000;
        tags[2]  = 5'd10;

        // Flush at pointer 3, then resume from 3 with wrap to FU0
        step(4'b1111, 1'b1, 4'b0000, 2'b00, 2'b00, 0, 0);
        chk("flush_wr_en", wr_en, 2'b00);
        chk("flush_cdb_valid", cdb_valid, 2'b00);
        step(4'b1111, 1'b0, 4'b1001, 2'b11, 2'b11, 3, 0);

        // Reset mid-operation returns pointer to 0
        @(negedge clock);
        #1;
        rst_n = 1'b0;
        drive(4'b1111, 1'b0);
        #1;
        chk("midreset_ready", req_ready, 4'b0000);
        chk("midreset_wr_en", wr_en, 2'b00);
        chk("midreset_cdb_valid", cdb_valid, 2'b00);
        @(posedge clock);
        #3;
        rst_n = 1'b1;
        step(4'b1111, 1'b0, 4'b0011, 2'b11, 2'b11, 0, 1);

        // Regfile integration: tags 0..31, two per cycle
        for (int k = 0; k < 16; k++) begin
            tags[0]  = 5'(2 * k);
            datas[0] = 32'(2 * k);
            tags[1]  = 5'(2 * k + 1);
            datas[1] = 32'(2 * k + 1);
            step(4'b0011, 1'b0, 4'b0011, 2'b11, (k == 0) ? 2'b10 : 2'b11, 0, 1);
        end
        drive(4'b0000, 1'b0);
        @(posedge clock);
        @(posedge clock);
        #1;
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("regfile_%0d", i), regs[i], (i == 0) ? 64'd0 : 64'(i));
        end
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
